dma_int_status_queue: RTL
=========================

// Module: dma_int_status_queue
// PURPOSE
//  Consumes one status record per cycle from the interrupt-status mux (descriptor-not-valid errors and
//  transfer completions), filters it against a per-event mask and buffers it in a FIFO for software.
//  Drives the DMA interrupt line and exposes the head record to the register block, which pops it on clear.
//  The upstream mux acks unconditionally, so this block has no back-pressure and drops records when full.
// PARAMETERS
//  NUM_INT_BDS_WIDTH  2  width of the internal descriptor number
//  FIFO_DEPTH_WIDTH   3  log2 of queue depth (default depth 8)
// PORTS
//  clock               in   1      clock
//  resetn              in   1      reset, asynchronous, active-low
//  stsValid            in   1      status record present this cycle (single-cycle, no ready)
//  stsOpDone           in   1      transfer completed
//  stsWrError          in   1      write-side error
//  stsRdError          in   1      read-side error
//  stsNValidError      in   1      descriptor-not-valid error
//  stsIntDscrptrNum    in   NIBW   internal descriptor number
//  stsExtDscrptr       in   1      external descriptor flag
//  stsExtDscrptrAddr   in   32     external descriptor address
//  stsStrDscrptr       in   1      stream descriptor flag
//  intMask             in   4      enables {nValidErr,rdErr,wrErr,opDone}; record queued only if flags&mask!=0
//  intClear            in   1      pop head (1-cycle pulse from register block)
//  ovflClear           in   1      clear sticky overflow
//  coalThresh          in   8      coalescing count threshold (used only with macro)
//  coalTimeout         in   16     coalescing timeout in cycles (used only with macro)
//  headValid           out  1      queue not empty
//  headRecord          out  38+NIBW  {nValidErr,rdErr,wrErr,opDone,strDscrptr,extDscrptr,intDscrptrNum,extAddr}
//  fifoCount           out  FDW+1  occupancy 0..depth
//  overflow            out  1      sticky: a qualified record was dropped
//  irq                 out  1      registered interrupt to the CPU
// BEHAVIOUR
//  - Reset: FIFO empty, headValid=0, headRecord=0, fifoCount=0, overflow=0, irq=0, coalescing state IDLE.
//  - Push: stsValid & |(flags&intMask) & (!full | intClear). Unqualified records are discarded silently.
//  - Latency: record pushed in cycle N is on headRecord/headValid in N+1 (when the FIFO was empty).
//  - Pop: intClear & !empty advances head; intClear on empty is ignored. headRecord=0 when empty.
//  - Full + push + intClear in the same cycle: both happen, count unchanged, no overflow.
//  - Full + push, no pop: record dropped, overflow<=1. ovflClear clears; a simultaneous drop wins (stays 1).
//  - fifoCount is exact; pointers wrap modulo depth with an extra wrap bit for full/empty.
//  - irq (no macro): irq <= (next fifoCount != 0); rises in N+1 after the first push, falls the cycle after last pop.
//  - Mid-operation reset: all state cleared asynchronously; records in flight are lost.
// CONFIGURATION
//  DMA_INT_COALESCE_EN defined: irq driven by 3-state FSM, 16-bit timer:
//   IDLE  (irq=0): count!=0 -> ARMED, timer<=0.
//   ARMED (irq=0): timer++; count>=max(coalThresh,1) or (coalTimeout!=0 & timer==coalTimeout-1) -> FIRE;
//                  count drops to 0 -> IDLE.
//   FIRE  (irq=1): stays until count==0 -> IDLE.
//  Undefined: FSM and timer absent; coalThresh/coalTimeout ignored; irq as above.
// STRUCTURE
//  - Package dma_int_status_pkg: record bit offsets, mask bit indices, coalescing state encoding.
//  - Sub-module dma_int_status_fifo: generic sync FIFO (data width, depth width params, push/pop/count/full/empty).
//  - Top holds qualification, overflow flag, irq/coalescing logic.
// TESTING
//  - Single record: stsValid, opDone=1, mask=4'b0001 -> headValid=1 and irq=1 next cycle; intClear -> both 0.
//  - Masked record: wrError=1, mask=4'b0001 -> fifoCount stays 0, irq stays 0, overflow 0.
//  - Fill 8, push 9th -> fifoCount=8, overflow=1, head is 1st record; 9th push with intClear -> accepted, no overflow.
//  - Order check: push addr 0x1000,0x2000,0x3000 -> popped in order; intClear on empty -> no change.
//  - Coalescing (macro): thresh=3, timeout=0 -> irq low after 2 pushes, high cycle after 3rd; timeout=10, 1 push -> irq at cycle 10.
//  - Reset asserted with 4 queued and irq=1 -> all outputs 0 immediately.

Source files
------------

// File: rtl/dma_int_status_pkg.sv
// Shared definitions for the DMA interrupt status queue: record layout, mask bit
// indices and the coalescing state encoding.
package dma_int_status_pkg;

  localparam int EXT_ADDR_W = 32;
  localparam int FLAG_W     = 4;

  // Bit positions inside intMask and inside the flag field of a record
  localparam int MASK_OP_DONE  = 0;
  localparam int MASK_WR_ERR   = 1;
  localparam int MASK_RD_ERR   = 2;
  localparam int MASK_NVAL_ERR = 3;

  // Record offsets measured from the LSB; the descriptor number sits between them
  localparam int REC_ADDR_LSB = 0;
  localparam int REC_NUM_LSB  = EXT_ADDR_W;

  typedef enum logic [1:0] {
    COAL_IDLE  = 2'd0,
    COAL_ARMED = 2'd1,
    COAL_FIRE  = 2'd2
  } coalState_t;

  function automatic int recWidth(input int nibw);
    return FLAG_W + 2 + nibw + EXT_ADDR_W;
  endfunction

endpackage

// File: rtl/dma_int_status_queue_if.sv
// Status-record bundle from the interrupt-status mux; single-cycle valid, no ready.
interface dma_int_status_queue_if #(
  parameter int NIBW = 2
);

  logic            stsValid;
  logic            stsOpDone;
  logic            stsWrError;
  logic            stsRdError;
  logic            stsNValidError;
  logic [NIBW-1:0] stsIntDscrptrNum;
  logic            stsExtDscrptr;
  logic [31:0]     stsExtDscrptrAddr;
  logic            stsStrDscrptr;

  modport master (
    output stsValid, stsOpDone, stsWrError, stsRdError, stsNValidError,
           stsIntDscrptrNum, stsExtDscrptr, stsExtDscrptrAddr, stsStrDscrptr
  );

  modport slave (
    input  stsValid, stsOpDone, stsWrError, stsRdError, stsNValidError,
           stsIntDscrptrNum, stsExtDscrptr, stsExtDscrptrAddr, stsStrDscrptr
  );

endinterface

// File: rtl/dma_int_status_fifo.sv
// Generic synchronous FIFO with exact occupancy count; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module dma_int_status_fifo #(
  parameter int DATA_WIDTH  = 40,
  parameter int DEPTH_WIDTH = 3
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wrData,
  output logic [DATA_WIDTH-1:0] rdData,
  output logic [DEPTH_WIDTH:0]  count,
  output logic [DEPTH_WIDTH:0]  countNext,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << DEPTH_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_WIDTH:0]  wrPtr;
  logic [DEPTH_WIDTH:0]  rdPtr;
  logic                  doPush;
  logic                  doPop;

  // Pointers carry an extra wrap bit so full and empty differ only in that bit
  assign empty  = (wrPtr == rdPtr);
  assign full   = (wrPtr[DEPTH_WIDTH] != rdPtr[DEPTH_WIDTH]) &&
                  (wrPtr[DEPTH_WIDTH-1:0] == rdPtr[DEPTH_WIDTH-1:0]);
  assign doPop  = pop & ~empty;
  assign doPush = push & (~full | doPop);
  assign rdData = mem[rdPtr[DEPTH_WIDTH-1:0]];

  always_comb begin
    countNext = count;
    case ({doPush, doPop})
      2'b10:   countNext = count + (DEPTH_WIDTH+1)'(1);
      2'b01:   countNext = count - (DEPTH_WIDTH+1)'(1);
      default: countNext = count;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + (DEPTH_WIDTH+1)'(1);
      if (doPop)  rdPtr <= rdPtr + (DEPTH_WIDTH+1)'(1);
      count <= countNext;
    end
  end

  always_ff @(posedge clock) begin
    if (doPush) mem[wrPtr[DEPTH_WIDTH-1:0]] <= wrData;
  end

endmodule

// File: rtl/dma_int_status_queue.sv
// DMA interrupt status queue: masks incoming status records, buffers them for software
// and drives the interrupt line. Define DMA_INT_COALESCE_EN to add interrupt coalescing.
module dma_int_status_queue
  import dma_int_status_pkg::*;
#(
  parameter int NUM_INT_BDS_WIDTH = 2,
  parameter int FIFO_DEPTH_WIDTH  = 3
) (
  input  logic                                   clock,
  input  logic                                   resetn,
  dma_int_status_queue_if.slave                  stsIf,
  input  logic [3:0]                             intMask,
  input  logic                                   intClear,
  input  logic                                   ovflClear,
  input  logic [7:0]                             coalThresh,
  input  logic [15:0]                            coalTimeout,
  output logic                                   headValid,
  output logic [recWidth(NUM_INT_BDS_WIDTH)-1:0] headRecord,
  output logic [FIFO_DEPTH_WIDTH:0]              fifoCount,
  output logic                                   overflow,
  output logic                                   irq
);

  localparam int REC_W = recWidth(NUM_INT_BDS_WIDTH);

  logic [FLAG_W-1:0]             flags;
  logic [REC_W-1:0]              inRecord;
  logic [REC_W-1:0]              fifoHead;
  logic [FIFO_DEPTH_WIDTH:0]     countNext;
  logic                          fifoFull;
  logic                          fifoEmpty;
  logic                          qualified;
  logic                          push;
  logic                          pop;
  logic                          drop;

  always_comb begin
    flags                = '0;
    flags[MASK_OP_DONE]  = stsIf.stsOpDone;
    flags[MASK_WR_ERR]   = stsIf.stsWrError;
    flags[MASK_RD_ERR]   = stsIf.stsRdError;
    flags[MASK_NVAL_ERR] = stsIf.stsNValidError;
  end

  assign inRecord  = {flags, stsIf.stsStrDscrptr, stsIf.stsExtDscrptr,
                      stsIf.stsIntDscrptrNum, stsIf.stsExtDscrptrAddr};
  assign qualified = stsIf.stsValid & (|(flags & intMask));
  // A full queue still takes the record when software pops in the same cycle
  assign push      = qualified & (~fifoFull | intClear);
  assign drop      = qualified & fifoFull & ~intClear;
  assign pop       = intClear & ~fifoEmpty;

  dma_int_status_fifo #(
    .DATA_WIDTH  (REC_W),
    .DEPTH_WIDTH (FIFO_DEPTH_WIDTH)
  ) uFifo (
    .clock     (clock),
    .resetn    (resetn),
    .push      (push),
    .pop       (pop),
    .wrData    (inRecord),
    .rdData    (fifoHead),
    .count     (fifoCount),
    .countNext (countNext),
    .full      (fifoFull),
    .empty     (fifoEmpty)
  );

  assign headValid  = ~fifoEmpty;
  assign headRecord = fifoEmpty ? '0 : fifoHead;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)         overflow <= 1'b0;
    else if (drop)       overflow <= 1'b1;
    else if (ovflClear)  overflow <= 1'b0;
  end

`ifdef DMA_INT_COALESCE_EN

  coalState_t                state;
  coalState_t                stateNext;
  logic [15:0]               timer;
  logic [8:0]                threshEff;
  logic [8:0]                countWide;
  logic                      timeoutHit;

  // Decisions look at next-cycle occupancy so the line reacts to this cycle's push/pop
  assign threshEff  = (coalThresh == 8'd0) ? 9'd1 : {1'b0, coalThresh};
  assign countWide  = 9'(countNext);
  assign timeoutHit = (coalTimeout != 16'd0) && (timer == coalTimeout - 16'd1);

  always_comb begin
    stateNext = state;
    case (state)
      COAL_IDLE: begin
        if (countNext != '0) stateNext = COAL_ARMED;
      end
      COAL_ARMED: begin
        if (countNext == '0)                            stateNext = COAL_IDLE;
        else if ((countWide >= threshEff) || timeoutHit) stateNext = COAL_FIRE;
      end
      COAL_FIRE: begin
        if (countNext == '0) stateNext = COAL_IDLE;
      end
      default: stateNext = COAL_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= COAL_IDLE;
      timer <= '0;
    end else begin
      state <= stateNext;
      if (state == COAL_ARMED) timer <= timer + 16'd1;
      else                     timer <= '0;
    end
  end

  assign irq = (state == COAL_FIRE);

`else

  logic unusedCoal;
  logic irqReg;

  assign unusedCoal = ^{coalThresh, coalTimeout};

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) irqReg <= 1'b0;
    else         irqReg <= (countNext != '0);
  end

  assign irq = irqReg;

`endif

endmodule
